// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S capture block.
// Holds the capture FSM states, channel tags and synchroniser depth.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAD
  } capture_state_t;

  typedef enum logic {
    CHAN_LEFT  = 1'b0,
    CHAN_RIGHT = 1'b1
  } i2s_chan_t;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/i2s_capture_fifo.sv
// Synchronous show-ahead FIFO: rd_data always shows the head entry.
// Ports: wr_en/wr_data in, rd_en pops head, full/empty status out.
module i2s_capture_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // A pop frees the slot in the same cycle, so a full FIFO
  // still accepts a write when the head is being consumed.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_capture.sv
// I2S receiver: oversamples bck/lrck/sdata, deserialises MSB-first words.
// Ports: I2S lines in, valid/ready word stream out, sticky error flags.
module i2s_capture
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear_flags,
  input  logic                    bck,
  input  logic                    lrck,
  input  logic                    sdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SAMPLE_WIDTH-1:0] out_data,
  output logic                    out_chan,
  output logic                    overflow,
  output logic                    frame_err
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam int SW = SAMPLE_WIDTH;

  logic [SYNC_DEPTH-1:0] bck_sync;
  logic [SYNC_DEPTH-1:0] lrck_sync;
  logic [SYNC_DEPTH-1:0] sdata_sync;
  logic                  bck_q;
  logic                  bck_s;
  logic                  lrck_s;
  logic                  sdata_s;
  logic                  rise;
  logic                  trans;
  logic                  lrck_prev;
  logic                  primed;

  capture_state_t state, state_n;
  logic [CW-1:0]  count, count_n;
  logic [SW-1:0]  shreg, shreg_n;
  i2s_chan_t      chan, chan_n;
  logic           done;
  logic           ferr_evt;
  logic           word_done;
  logic           ovf_evt;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [SW:0]    fifo_rd;

  assign bck_s   = bck_sync[SYNC_DEPTH-1];
  assign lrck_s  = lrck_sync[SYNC_DEPTH-1];
  assign sdata_s = sdata_sync[SYNC_DEPTH-1];
  assign rise    = bck_s & ~bck_q;

  // The first rise after reset only learns the current lrck level,
  // so a slot already in progress at reset is never mistaken for a
  // fresh word boundary.
  assign trans = rise & primed & (lrck_s != lrck_prev);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bck_sync   <= '0;
      lrck_sync  <= '0;
      sdata_sync <= '0;
      bck_q      <= 1'b0;
      lrck_prev  <= 1'b0;
      primed     <= 1'b0;
    end else begin
      bck_sync   <= {bck_sync[SYNC_DEPTH-2:0], bck};
      lrck_sync  <= {lrck_sync[SYNC_DEPTH-2:0], lrck};
      sdata_sync <= {sdata_sync[SYNC_DEPTH-2:0], sdata};
      bck_q      <= bck_s;
      if (rise) begin
        lrck_prev <= lrck_s;
        primed    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      shreg     <= '0;
      chan      <= CHAN_LEFT;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      shreg     <= shreg_n;
      chan      <= chan_n;
      word_done <= done;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    shreg_n  = shreg;
    chan_n   = chan;
    done     = 1'b0;
    ferr_evt = 1'b0;
    unique case (state)
      IDLE: begin
        if (trans && enable) begin
          state_n = SHIFT;
          count_n = '0;
          shreg_n = '0;
          chan_n  = i2s_chan_t'(lrck_s);
        end
      end
      SHIFT: begin
        if (trans) begin
          ferr_evt = 1'b1;
          count_n  = '0;
          shreg_n  = '0;
          chan_n   = i2s_chan_t'(lrck_s);
          state_n  = enable ? SHIFT : IDLE;
        end else if (rise) begin
          shreg_n = {shreg[SW-2:0], sdata_s};
          count_n = count + 1'b1;
          if (count == CW'(SW - 1)) begin
            done    = 1'b1;
            state_n = PAD;
          end
        end
      end
      PAD: begin
        if (trans) begin
          count_n = '0;
          shreg_n = '0;
          chan_n  = i2s_chan_t'(lrck_s);
          state_n = enable ? SHIFT : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop     = out_valid & out_ready;
  assign ovf_evt = word_done & fifo_full & ~pop;

  i2s_capture_fifo #(
    .WIDTH (SW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (word_done),
    .wr_data ({chan, shreg}),
    .rd_en   (out_ready),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_rd[SW-1:0];
  assign out_chan  = fifo_rd[SW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= ovf_evt | (overflow & ~clear_flags);
      frame_err <= ferr_evt | (frame_err & ~clear_flags);
    end
  end

endmodule
